// File: rtl/obstacle_map_arbiter_if.sv
// Map-ROM arbiter bus: display and physics read ports, flush, ROM side.
// slave = arbiter view, master = requester/ROM view.
interface obstacle_map_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          flush;

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_valid;
  logic [DW-1:0] disp_data;

  logic          phy_req;
  logic [AW-1:0] phy_addr;
  logic          phy_gnt;
  logic          phy_valid;
  logic [DW-1:0] phy_data;

  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  modport slave (
    input  flush,
    input  disp_req,
    input  disp_addr,
    output disp_gnt,
    output disp_valid,
    output disp_data,
    input  phy_req,
    input  phy_addr,
    output phy_gnt,
    output phy_valid,
    output phy_data,
    output rom_en,
    output rom_addr,
    input  rom_data
  );

  modport master (
    output flush,
    output disp_req,
    output disp_addr,
    input  disp_gnt,
    input  disp_valid,
    input  disp_data,
    output phy_req,
    output phy_addr,
    input  phy_gnt,
    input  phy_valid,
    input  phy_data,
    input  rom_en,
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/obstacle_map_arbiter.sv
// Shares the obstacle-map ROM between display (priority) and physics
// (starvation-protected). Ports: sys_clk, sys_rst (sync, active-high),
// bus (slave modport: req/addr/gnt/valid/data per requester, flush,
// rom_en/rom_addr/rom_data). Optional OBSTACLE_ARB_STATS_EN adds
// stat_forced_cnt, a saturating count of forced physics grants.
module obstacle_map_arbiter #(
  parameter int MAP_ADDR_WIDTH = 10,
  parameter int MAP_DATA_WIDTH = 8,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  obstacle_map_arbiter_if.slave bus
`ifdef OBSTACLE_ARB_STATS_EN
  ,
  output logic [15:0] stat_forced_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_PHY = 1'b1
  } state_e;

  // owner: 0 = display, 1 = physics
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  state_e state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic disp_gnt;
  logic phy_gnt;
  logic any_gnt;

  tag_t tag0_q, tag0_d;
  tag_t tag1_q;

  logic                      rom_en_q;
  logic [MAP_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;

  logic                      disp_valid_q, disp_valid_d;
  logic                      phy_valid_q, phy_valid_d;
  logic [MAP_DATA_WIDTH-1:0] disp_data_q;
  logic [MAP_DATA_WIDTH-1:0] phy_data_q;

  // Arbitration, starvation count and FSM next state.
  always_comb begin
    disp_gnt     = 1'b0;
    phy_gnt      = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    if (!sys_rst) begin
      unique case (state_q)
        NORMAL: begin
          disp_gnt = bus.disp_req;
          phy_gnt  = bus.phy_req & ~bus.disp_req;
        end
        FORCE_PHY: begin
          phy_gnt  = bus.phy_req;
        end
      endcase
    end

    if (bus.flush || !bus.phy_req || phy_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // The forced cycle is the one in which the registered count
    // sits at the limit, so the decision is taken on the value
    // being loaded into the count register.
    unique case (state_q)
      NORMAL: begin
        if (starve_cnt_d == LIMIT) begin
          state_d = FORCE_PHY;
        end
      end
      FORCE_PHY: begin
        state_d = NORMAL;
      end
    endcase

    if (bus.flush) begin
      state_d = NORMAL;
    end
  end

  assign any_gnt = disp_gnt | phy_gnt;

  // Issue stage: reads granted during flush still go to the ROM,
  // but their tag is dropped so no result is returned.
  always_comb begin
    tag0_d.valid = any_gnt & ~bus.flush;
    tag0_d.owner = phy_gnt;
    rom_addr_d   = rom_addr_q;
    if (phy_gnt) begin
      rom_addr_d = bus.phy_addr;
    end else if (disp_gnt) begin
      rom_addr_d = bus.disp_addr;
    end
  end

  // Return stage: a flush also kills the read whose data is on the
  // ROM bus this cycle.
  always_comb begin
    disp_valid_d = tag1_q.valid & ~tag1_q.owner & ~bus.flush;
    phy_valid_d  = tag1_q.valid &  tag1_q.owner & ~bus.flush;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= NORMAL;
      starve_cnt_q <= 4'd0;
      tag0_q       <= '0;
      tag1_q       <= '0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      disp_valid_q <= 1'b0;
      phy_valid_q  <= 1'b0;
      disp_data_q  <= '0;
      phy_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tag0_q       <= tag0_d;
      tag1_q       <= bus.flush ? '0 : tag0_q;
      rom_en_q     <= any_gnt;
      rom_addr_q   <= rom_addr_d;
      disp_valid_q <= disp_valid_d;
      phy_valid_q  <= phy_valid_d;
      if (disp_valid_d) begin
        disp_data_q <= bus.rom_data;
      end
      if (phy_valid_d) begin
        phy_data_q <= bus.rom_data;
      end
    end
  end

  assign bus.disp_gnt   = disp_gnt;
  assign bus.phy_gnt    = phy_gnt;
  assign bus.rom_en     = rom_en_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.phy_valid  = phy_valid_q;
  assign bus.phy_data   = phy_data_q;

`ifdef OBSTACLE_ARB_STATS_EN
  logic [15:0] stat_q;

  // Survives flush; only reset clears it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stat_q <= '0;
    end else if (state_q == FORCE_PHY && phy_gnt &&
                 stat_q != 16'hFFFF) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_forced_cnt = stat_q;
`endif

endmodule

// File: tb/tb_obstacle_map_arbiter.sv
// Self-checking bench for obstacle_map_arbiter: directed scenarios
// plus random traffic against a cycle-level reference model.
module tb_obstacle_map_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  obstacle_map_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef OBSTACLE_ARB_STATS_EN
  logic [15:0] stat_forced_cnt;
`endif

  obstacle_map_arbiter #(
    .MAP_ADDR_WIDTH(AW),
    .MAP_DATA_WIDTH(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
`ifdef OBSTACLE_ARB_STATS_EN
    ,
    .stat_forced_cnt(stat_forced_cnt)
`endif
  );

  // Synchronous ROM model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge sys_clk) begin
    if (bus.rom_en) bus.rom_data <= mem[bus.rom_addr];
  end

  int tests = 0;
  int fails = 0;

  // Reference model state
  int       denied;
  bit       sv_d [0:7];
  bit       sv_p [0:7];
  logic [DW-1:0] sdat [0:7];
  logic [DW-1:0] e_ddat, e_pdat;
  int       cyc_n;
  int       e_forced;
  bit       last_dg, last_pg;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    denied = 0;
    for (int k = 0; k < 8; k++) begin
      sv_d[k] = 0;
      sv_p[k] = 0;
      sdat[k] = '0;
    end
    e_ddat = '0;
    e_pdat = '0;
  endtask

  // One clock cycle: drive, check mid-cycle, advance model.
  task automatic cyc(input logic rst, input logic fl,
                     input logic dr, input logic [AW-1:0] da,
                     input logic pr, input logic [AW-1:0] pa);
    bit forced, eg_d, eg_p;
    int s, t;
    sys_rst       = rst;
    bus.flush     = fl;
    bus.disp_req  = dr;
    bus.disp_addr = da;
    bus.phy_req   = pr;
    bus.phy_addr  = pa;
    #3;
    forced = (denied == LIM);
    eg_d = !rst && dr && !forced;
    eg_p = !rst && pr && (forced || !dr);
    chk("disp_gnt", bus.disp_gnt, eg_d);
    chk("phy_gnt", bus.phy_gnt, eg_p);
    s = cyc_n % 8;
    if (sv_d[s]) e_ddat = sdat[s];
    if (sv_p[s]) e_pdat = sdat[s];
    chk("disp_valid", bus.disp_valid, sv_d[s]);
    chk("phy_valid", bus.phy_valid, sv_p[s]);
    chk("disp_data", bus.disp_data, e_ddat);
    chk("phy_data", bus.phy_data, e_pdat);
    sv_d[s] = 0;
    sv_p[s] = 0;
    last_dg = eg_d;
    last_pg = eg_p;
    if (rst) begin
      model_clear();
      e_forced = 0;
    end else begin
      if (forced && eg_p && e_forced < 65535) e_forced++;
      if (fl) begin
        denied = 0;
        for (int k = 1; k <= 3; k++) begin
          sv_d[(cyc_n + k) % 8] = 0;
          sv_p[(cyc_n + k) % 8] = 0;
        end
      end else begin
        if (eg_d || eg_p) begin
          t = (cyc_n + 3) % 8;
          sv_d[t] = eg_d;
          sv_p[t] = eg_p;
          sdat[t] = mem[eg_p ? pa : da];
        end
        if (pr && !eg_p) denied = (denied < LIM) ? denied + 1 : LIM;
        else denied = 0;
      end
    end
    @(posedge sys_clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    logic          dp, pp, fl;
    logic [AW-1:0] ra, rb, pa;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[10'h005] = 8'h3C;
    mem[10'h3FF] = 8'hA5;

    // Reset state
    sys_rst = 1'b1;
    bus.flush = 1'b1;
    bus.disp_req = 1'b1;
    bus.disp_addr = '0;
    bus.phy_req = 1'b1;
    bus.phy_addr = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    model_clear();
    cyc_n = 0;
    e_forced = 0;
    chk("rst_disp_gnt", bus.disp_gnt, 0);
    chk("rst_phy_gnt", bus.phy_gnt, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_phy_valid", bus.phy_valid, 0);
    chk("rst_disp_data", bus.disp_data, 0);
    chk("rst_phy_data", bus.phy_data, 0);
    idle(2);

    // Single display read
    cyc(0, 0, 1, 10'h005, 0, '0);
    chk("sd_rom_en", bus.rom_en, 1);
    chk("sd_rom_addr", bus.rom_addr, 10'h005);
    idle(2);
    chk("sd_valid", bus.disp_valid, 1);
    chk("sd_data", bus.disp_data, 8'h3C);
    idle(2);

    // Single physics read
    cyc(0, 0, 0, '0, 1, 10'h005);
    chk("sp_rom_en", bus.rom_en, 1);
    chk("sp_rom_addr", bus.rom_addr, 10'h005);
    idle(2);
    chk("sp_valid", bus.phy_valid, 1);
    chk("sp_data", bus.phy_data, 8'h3C);
    idle(2);

    // Contention: 4 display grants then one physics, period 5
    pa = 10'd100;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 1, AW'(i), 1, pa);
      chk($sformatf("cont_phy%0d", i), last_pg, (i % 5) == 4);
      chk($sformatf("cont_disp%0d", i), last_dg, (i % 5) != 4);
      if (last_pg) pa = pa + 10'd1;
    end
    idle(4);
`ifdef OBSTACLE_ARB_STATS_EN
    chk("stat_cont", stat_forced_cnt, 3);
`endif

    // Back-to-back streaming 0..7
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, AW'(i), 0, '0);
    idle(4);

    // Flush with two reads in flight
    cyc(0, 0, 1, 10'd10, 0, '0);
    cyc(0, 0, 0, '0, 1, 10'd20);
    cyc(0, 1, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, AW'(30 + i), 1, 10'd40);
      chk($sformatf("fl_phy%0d", i), last_pg, i == 4);
    end
    idle(4);

    // Reset during streaming
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, AW'(i), 0, '0);
    cyc(1, 0, 1, 10'd3, 1, 10'd9);
    chk("mr_rom_en", bus.rom_en, 0);
    chk("mr_rom_addr", bus.rom_addr, 0);
    chk("mr_disp_valid", bus.disp_valid, 0);
    chk("mr_phy_valid", bus.phy_valid, 0);
    chk("mr_disp_data", bus.disp_data, 0);
    chk("mr_phy_data", bus.phy_data, 0);
    idle(5);

    // Top address
    cyc(0, 0, 1, 10'h3FF, 0, '0);
    idle(2);
    chk("top_valid", bus.disp_valid, 1);
    chk("top_data", bus.disp_data, 8'hA5);
    idle(2);

    // phy_req drops in the forced cycle
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, AW'(50 + i), 1, 10'd60);
    cyc(0, 0, 1, 10'd54, 0, '0);
    chk("drop_disp", last_dg, 0);
    chk("drop_phy", last_pg, 0);
    cyc(0, 0, 1, 10'd54, 0, '0);
    chk("drop_normal", last_dg, 1);
    idle(4);

    // Random traffic honouring hold-until-grant
    dp = 0;
    pp = 0;
    ra = '0;
    rb = '0;
    for (int i = 0; i < 600; i++) begin
      if (!dp && $urandom_range(0, 9) < 6) begin
        dp = 1;
        ra = AW'($urandom);
      end
      if (!pp && $urandom_range(0, 9) < 5) begin
        pp = 1;
        rb = AW'($urandom);
      end
      fl = ($urandom_range(0, 39) == 0);
      cyc(0, fl, dp, ra, pp, rb);
      if (last_dg) dp = 0;
      if (last_pg) pp = 0;
    end
    idle(4);

`ifdef OBSTACLE_ARB_STATS_EN
    chk("stat_final", stat_forced_cnt, e_forced);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
